// File: rtl/synth_pkg.sv
// synth_pkg: shared constants and encodings for the note-index to square-wave datapath.
package synth_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned NOTE_W = 6;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  typedef enum logic [1:0] {
    DUTY_12P5 = 2'b00,
    DUTY_25   = 2'b01,
    DUTY_50   = 2'b10,
    DUTY_75   = 2'b11
  } duty_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tone_state_e;

endpackage

// File: rtl/note_period_rom.sv
// note_period_rom: registered lookup of the half-period count per note index.
// Entry n>=1 is round(CLK_HZ / (2 * C2 * 2^((n-1)/12))); entry 0 (rest) is 0.
module note_period_rom
  import synth_pkg::*;
#(
  parameter int unsigned CLK_HZ = synth_pkg::CLK_HZ,
  parameter int unsigned CNT_W  = 19,
  parameter int unsigned NOTE_W = synth_pkg::NOTE_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NOTE_W-1:0] addr_i,
  output logic [CNT_W-1:0]  half_o
);

  localparam int unsigned      DEPTH  = 1 << NOTE_W;
  localparam longint unsigned  REF_HZ = 64'd50_000_000;

  // Half-period counts at the 50 MHz reference; rescaled below for other clocks.
  localparam int unsigned HALF_TBL [64] = '{
         0, 382225, 360773, 340524, 321412, 303372, 286345, 270274,
    255105, 240787, 227273, 214517, 202477, 191113, 180386, 170262,
    160706, 151686, 143173, 135137, 127552, 120393, 113636, 107258,
    101238,  95556,  90193,  85131,  80353,  75843,  71586,  67569,
     63776,  60197,  56818,  53629,  50619,  47778,  45097,  42566,
     40176,  37922,  35793,  33784,  31888,  30098,  28409,  26815,
     25310,  23889,  22548,  21283,  20088,  18961,  17897,  16892,
     15944,  15049,  14205,  13407,  12655,  11945,  11274,  10641
  };

  logic [CNT_W-1:0] rom [DEPTH];
  logic [CNT_W-1:0] half_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    if (g < 64) begin : g_tbl
      localparam longint unsigned SCALED =
        (64'(HALF_TBL[g]) * 64'(CLK_HZ) + REF_HZ / 2) / REF_HZ;
      assign rom[g] = CNT_W'(SCALED);
    end else begin : g_pad
      assign rom[g] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      half_q <= '0;
    end else begin
      half_q <= rom[addr_i];
    end
  end

  assign half_o = half_q;

endmodule

// File: rtl/note_tone_gen.sv
// note_tone_gen: note index -> square-wave tone; pitch/rest changes applied only on waveform edges.
// Build option TONE_DUTY_EN: full-period counter with 12.5/25/50/75 % duty from duty_sel.
module note_tone_gen
  import synth_pkg::*;
#(
  parameter int unsigned CLK_HZ = synth_pkg::CLK_HZ,
  parameter int unsigned CNT_W  = 19,
  parameter int unsigned NOTE_W = synth_pkg::NOTE_W
) (
  input  logic              clk50mhz,
  input  logic              rst_n,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              en,
  input  logic [1:0]        duty_sel,
  output logic              tone_out,
  output logic              note_active,
  output logic              edge_stb
);

`ifdef TONE_DUTY_EN
  localparam int unsigned PW = CNT_W + 1;
`else
  localparam int unsigned PW = CNT_W;
`endif

  tone_state_e       state_q;
  logic [NOTE_W-1:0] note_q;
  logic [CNT_W-1:0]  pending_half;
  logic [PW-1:0]     cnt_q;
  logic [PW-1:0]     cnt_inc;
  logic [PW-1:0]     end_q;
  logic [PW-1:0]     pend_end;
  logic              tone_q;
  logic              stb_q;
  logic              at_end;

  note_period_rom #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W),
    .NOTE_W (NOTE_W)
  ) u_rom (
    .clk_i  (clk50mhz),
    .rst_ni (rst_n),
    .addr_i (note_q),
    .half_o (pending_half)
  );

`ifdef TONE_DUTY_EN
  logic [PW-1:0] duty_q;
  logic [PW-1:0] duty_d;

  function automatic logic [PW-1:0] duty_len(input duty_e sel, input logic [CNT_W-1:0] h);
    logic [PW-1:0] hx;
    hx = PW'(h);
    case (sel)
      DUTY_12P5: duty_len = hx >> 2;
      DUTY_25:   duty_len = hx >> 1;
      DUTY_50:   duty_len = hx;
      DUTY_75:   duty_len = hx + (hx >> 1);
      default:   duty_len = hx;
    endcase
  endfunction

  always_comb begin
    duty_d   = duty_len(duty_e'(duty_sel), pending_half);
    pend_end = {pending_half, 1'b0} - PW'(1);
  end
`else
  logic duty_unused;
  assign duty_unused = ^duty_sel;

  always_comb begin
    pend_end = pending_half - PW'(1);
  end
`endif

  // end_q holds active_half-1 (or 2H-1 with duty); >= keeps a shrinking period from overrunning.
  always_comb begin
    cnt_inc = cnt_q + PW'(1);
    at_end  = (cnt_q >= end_q);
  end

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      note_q  <= NOTE_REST;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      end_q   <= '0;
      tone_q  <= 1'b0;
      stb_q   <= 1'b0;
`ifdef TONE_DUTY_EN
      duty_q  <= '0;
`endif
    end else begin
      note_q <= note_in;
      stb_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tone_q <= 1'b0;
          cnt_q  <= '0;
          if (en && (pending_half != '0)) begin
            state_q <= ST_RUN;
            end_q   <= pend_end;
            // Parked on the end count so the first rising edge lands on the next cycle.
            cnt_q   <= pend_end;
          end
        end
        ST_RUN: begin
          if (!en || (at_end && (pending_half == '0))) begin
            state_q <= ST_IDLE;
            tone_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (at_end) begin
            cnt_q <= '0;
            end_q <= pend_end;
`ifdef TONE_DUTY_EN
            duty_q <= duty_d;
            tone_q <= (duty_d != '0);
            stb_q  <= ((duty_d != '0) != tone_q);
`else
            tone_q <= ~tone_q;
            stb_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_inc;
`ifdef TONE_DUTY_EN
            tone_q <= (cnt_inc < duty_q);
            stb_q  <= ((cnt_inc < duty_q) != tone_q);
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tone_out    = tone_q;
  assign note_active = (state_q == ST_RUN);
  assign edge_stb    = stb_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: directed self-checking bench for note_tone_gen (default and TONE_DUTY_EN builds).
module tb_note_tone_gen;

  logic       clk50mhz = 1'b0;
  logic       rst_n;
  logic [5:0] note_in;
  logic       en;
  logic [1:0] duty_sel;
  logic       tone_out;
  logic       note_active;
  logic       edge_stb;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  always #10 clk50mhz = ~clk50mhz;

  note_tone_gen dut (
    .clk50mhz    (clk50mhz),
    .rst_n       (rst_n),
    .note_in     (note_in),
    .en          (en),
    .duty_sel    (duty_sel),
    .tone_out    (tone_out),
    .note_active (note_active),
    .edge_stb    (edge_stb)
  );

  task automatic check_eq(input string tag, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Cycles until the next edge_stb pulse; returns limit if none shows up.
  task automatic wait_stb(input int unsigned limit, output int unsigned n);
    n = 0;
    do begin
      @(negedge clk50mhz);
      n++;
    end while (!edge_stb && (n < limit));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned rom_note [6] = '{0, 1, 10, 34, 46, 63};
  int unsigned rom_exp  [6] = '{0, 382225, 227273, 56818, 28409, 10641};

  initial begin
    int unsigned n;
    int unsigned stbs;

    rst_n    = 1'b0;
    en       = 1'b0;
    note_in  = 6'd0;
    duty_sel = 2'b10;
    repeat (3) @(negedge clk50mhz);
    check_eq("rst_tone", tone_out, 0);
    check_eq("rst_active", note_active, 0);
    check_eq("rst_stb", edge_stb, 0);
    check_eq("rst_rom", dut.u_rom.half_o, 0);
    rst_n = 1'b1;

    foreach (rom_note[i]) begin
      note_in = rom_note[i][5:0];
      repeat (2) @(negedge clk50mhz);
      check_eq($sformatf("rom_%0d", rom_note[i]), dut.u_rom.half_o, rom_exp[i]);
    end
    check_eq("idle_en0_tone", tone_out, 0);

    note_in = 6'd0;
    repeat (3) @(negedge clk50mhz);
    note_in = 6'd63;
    en      = 1'b1;
    wait_stb(20, n);
    check_eq("startup_lat", n, 4);
    check_eq("startup_tone", tone_out, 1);
    check_eq("startup_active", note_active, 1);

`ifdef TONE_DUTY_EN
    duty_sel = 2'b01;
    wait_stb(10641 + 16, n);
    check_eq("duty50_hi", n, 10641);
    check_eq("duty50_fall", tone_out, 0);
    wait_stb(10641 + 16, n);
    check_eq("duty50_lo", n, 10641);
    check_eq("duty25_rise", tone_out, 1);
    repeat (1000) @(negedge clk50mhz);
    duty_sel = 2'b11;
    wait_stb(5320 + 16, n);
    check_eq("duty25_hi", 1000 + n, 5320);
    wait_stb(15962 + 16, n);
    check_eq("duty25_lo", n, 15962);
    wait_stb(15961 + 16, n);
    check_eq("duty75_hi", n, 15961);
    check_eq("duty75_fall", tone_out, 0);
`else
    wait_stb(10641 + 16, n);
    check_eq("half_hi_63", n, 10641);
    check_eq("fall_tone", tone_out, 0);
    wait_stb(10641 + 16, n);
    check_eq("half_lo_63", n, 10641);
    check_eq("rise_tone", tone_out, 1);

    repeat (3000) @(negedge clk50mhz);
    note_in = 6'd58;
    wait_stb(10641 + 16, n);
    check_eq("gliss_cur_half", 3000 + n, 10641);
    check_eq("gliss_fall", tone_out, 0);
    wait_stb(14205 + 16, n);
    check_eq("gliss_new_half", n, 14205);
    check_eq("gliss_rise", tone_out, 1);

    repeat (100) @(negedge clk50mhz);
    note_in = 6'd0;
    n    = 0;
    stbs = 0;
    do begin
      @(negedge clk50mhz);
      n++;
      if (edge_stb) stbs++;
    end while (tone_out && (n < 14205 + 16));
    check_eq("rest_half", 100 + n, 14205);
    check_eq("rest_active", note_active, 0);
    repeat (50) begin
      @(negedge clk50mhz);
      if (edge_stb || tone_out) stbs++;
    end
    check_eq("rest_quiet", stbs, 0);
`endif

    en      = 1'b0;
    note_in = 6'd63;
    repeat (4) @(negedge clk50mhz);
    check_eq("en0_tone", tone_out, 0);
    check_eq("en0_active", note_active, 0);
    en = 1'b1;
    wait_stb(20, n);
    check_eq("restart_lat", n, 2);
    check_eq("restart_tone", tone_out, 1);

    repeat (500) @(negedge clk50mhz);
    en = 1'b0;
    @(negedge clk50mhz);
    check_eq("endrop_tone", tone_out, 0);
    check_eq("endrop_active", note_active, 0);
    check_eq("endrop_stb", edge_stb, 0);
    en = 1'b1;
    wait_stb(20, n);
    check_eq("reraise_lat", n, 2);
    check_eq("reraise_tone", tone_out, 1);

    repeat (200) @(negedge clk50mhz);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_tone", tone_out, 0);
    check_eq("arst_active", note_active, 0);
    check_eq("arst_stb", edge_stb, 0);
    @(negedge clk50mhz);
    check_eq("arst_rom", dut.u_rom.half_o, 0);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
